clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
Runtime-programmable clock divider with a request/grant front end. Several requesters (e.g. encoder core, output serializer) ask for a new divide factor. A round-robin arbiter picks one request and holds it pending. The new factor is applied only at a full-period boundary of CLK_OUT, so the divided clock never glitches or produces a runt pulse.

Parameters:
NREQ, 2, number of requesters (2..8)
CNT_W, 10, width of divide factor and internal counter
DEFAULT_DIV, 1, divide factor loaded at reset

Ports:
CLK_IN  input  1  system clock
nRST  input  1  synchronous active-low reset, sampled on posedge CLK_IN
REQ  input  NREQ  per-requester change request; hold high until GNT
DIV_REQ  input  NREQ*CNT_W  requested factor, slice i belongs to REQ[i]
GNT  output  NREQ  one-cycle pulse; factor of requester i now in effect
BUSY  output  1  high while a request is latched and not yet applied
CUR_DIV  output  CNT_W  divide factor currently in effect
CLK_OUT  output  1  divided clock, registered
TICK  output  1  one-cycle pulse on every cycle in which CLK_OUT toggles

Behaviour:
- One clock (CLK_IN). Reset is synchronous, active-low (nRST).
- Reset values: CLK_OUT=1, counter=0, CUR_DIV=DEFAULT_DIV, GNT=0, TICK=0, BUSY=0, RR pointer=0, FSM=IDLE, pending register cleared.
- Reset takes effect mid-operation at any time. A pending request is dropped and no GNT is issued for it.
- Divider core:
  - half = CUR_DIV>>1.
  - If counter != half: counter+1.
  - Else: counter<=0, CLK_OUT toggles, TICK=1 that cycle.
  - CLK_OUT half-period = half+1 cycles; full period = 2*(half+1).
  - CUR_DIV=0 or 1 gives a toggle every cycle.
- "Boundary" = the terminal-count cycle in which CLK_OUT goes 0->1.
- FSM:
  - IDLE: if any REQ, arbitrate. Latch winner index and its DIV_REQ slice. Go to PEND; BUSY=1 from the next cycle.
  - PEND: on the boundary cycle, CUR_DIV<=latched value, counter<=0, CLK_OUT<=1, GNT[winner] pulses in that same cycle. RR pointer<=winner+1 (mod NREQ). Go to IDLE.
  - BUSY=1 exactly while in PEND.
- Latency:
  - Request to latch: 1 cycle.
  - Latch to GNT: up to one full old period.
  - The first period at the new factor starts the cycle after GNT.
- Arbitration: round-robin starting from the RR pointer. Among simultaneous requests, the lowest index at or above the pointer wins, wrapping around.
- A request dropped while in PEND is still applied and GNT still pulses. Requesters must ignore a GNT they no longer need.
- REQ seen while in PEND is not arbitrated until return to IDLE, so at most one change is applied per boundary.
- GNT and BUSY fall in the same cycle. A requester that holds REQ high through GNT is re-arbitrated only if REQ is still high the cycle after GNT.
- Width: counter and compare are CNT_W bits and never overflow, since half < 2^(CNT_W-1).

Optional Feature:
Macro CLK_DIV_CTRL_GATE_EN.
- Defined:
  - Adds input GATE (1 bit). When GATE=1, the core completes to the next boundary, then freezes with CLK_OUT=1, counter=0, TICK=0.
  - While frozen, a PEND request is applied immediately, with GNT one cycle after latch.
  - On GATE=0 the core resumes counting from 0 with CLK_OUT=1.
- Undefined: no GATE port; the core always runs.

Decomposition:
- Shared package: FSM state encoding (IDLE, PEND), DEFAULT_DIV constant, CNT_W constant.
- One natural sub-module, rr_arbiter (NREQ requests, pointer input, one-hot grant plus index output). Reusable elsewhere in the codebase.

Test Plan:
- Reset/default: DEFAULT_DIV=1, hold nRST low 5 cycles then release -> CLK_OUT=1 at release, toggles every cycle after, TICK high every cycle, GNT=0, BUSY=0.
- Single request: REQ[0]=1 with DIV=4 while CLK_OUT=1 -> BUSY next cycle. GNT[0] pulses on the next 0->1 boundary. Afterwards CLK_OUT is 3 high / 3 low, CUR_DIV=4.
- Simultaneous requests: REQ=2'b11, DIV0=6, DIV1=8, pointer=0 -> GNT[0] first with period 8. Then GNT[1] at the following boundary with period 10, CUR_DIV=8.
- Withdrawn request: REQ[1] pulsed for 1 cycle with DIV=2 -> still latched, GNT[1] pulses at the boundary, CUR_DIV=2.
- Reset mid-PEND: latch DIV=10, assert nRST before the boundary -> no GNT, CUR_DIV=DEFAULT_DIV, CLK_OUT=1.
- Gate (CLK_DIV_CTRL_GATE_EN): at DIV=4, raise GATE mid-high-phase -> CLK_OUT finishes its low phase, rises, stays 1 with no TICK. Request DIV=6 while gated -> GNT after 2 cycles. Drop GATE -> 4 high / 4 low.

Source files
------------

// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and defaults for the clk_div_ctrl divider and its request front end.
package clk_div_ctrl_pkg;
   localparam int CLK_DIV_CNT_W       = 10;
   localparam int CLK_DIV_DEFAULT_DIV = 1;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, combinational: lowest requester at or above ptr wins, wrapping.
// No storage and no backpressure; the caller owns and advances the pointer.
module rr_arbiter #(
   parameter int NREQ  = 2,
   parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] idx,
   output logic             vld
);

   always_comb begin
      int j;
      j   = 0;
      gnt = '0;
      idx = '0;
      vld = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         j = int'(ptr) + i;
         if (j >= NREQ) j = j - NREQ;
         if (!vld && req[j]) begin
            vld    = 1'b1;
            gnt[j] = 1'b1;
            idx    = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Glitch-free programmable clock divider; new factors apply only at a CLK_OUT rising boundary.
// Optional CLK_DIV_CTRL_GATE_EN adds GATE, which parks CLK_OUT high at the next boundary.
module clk_div_ctrl
   import clk_div_ctrl_pkg::*;
#(
   parameter int NREQ        = 2,
   parameter int CNT_W       = CLK_DIV_CNT_W,
   parameter int DEFAULT_DIV = CLK_DIV_DEFAULT_DIV
) (
   input  logic                  CLK_IN,
   input  logic                  nRST,
   input  logic [NREQ-1:0]       REQ,
   input  logic [NREQ*CNT_W-1:0] DIV_REQ,
`ifdef CLK_DIV_CTRL_GATE_EN
   input  logic                  GATE,
`endif
   output logic [NREQ-1:0]       GNT,
   output logic                  BUSY,
   output logic [CNT_W-1:0]      CUR_DIV,
   output logic                  CLK_OUT,
   output logic                  TICK
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   half;
   logic [CNT_W-1:0]   pend_div;
   logic [CNT_W-1:0]   sel_div;
   logic [IDX_W-1:0]   pend_idx;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   nxt_ptr;
   logic [NREQ-1:0]    arb_gnt;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_vld;
   logic               arb_en;
   logic               terminal;
   logic               boundary;
   logic               hold;
   logic               apply;
   logic               take;

   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req (REQ),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .vld (arb_vld)
   );

   assign half     = CUR_DIV >> 1;
   assign terminal = (cnt == half);
`ifdef CLK_DIV_CTRL_GATE_EN
   // Parked at the start of a high phase: counter idle, CLK_OUT held high.
   assign hold     = GATE && CLK_OUT && (cnt == '0);
`else
   assign hold     = 1'b0;
`endif
   assign boundary = !hold && terminal && !CLK_OUT;
   assign apply    = (state == PEND) && (boundary || hold);
   // Arbitration skips the GNT cycle so a requester has one cycle to drop REQ.
   assign arb_en   = (state == IDLE) && (GNT == '0);
   assign take     = arb_en && arb_vld;
   assign sel_div  = DIV_REQ[arb_idx*CNT_W +: CNT_W];
   assign nxt_ptr  = (pend_idx == IDX_W'(NREQ-1)) ? '0 : pend_idx + 1'b1;
   assign BUSY     = (state == PEND);

   always_ff @(posedge CLK_IN) begin
      if (!nRST) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take)  state_nxt = PEND;
         PEND:    if (apply) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK_IN) begin
      if (!nRST) begin
         cnt      <= '0;
         CLK_OUT  <= 1'b1;
         TICK     <= 1'b0;
         GNT      <= '0;
         CUR_DIV  <= CNT_W'(DEFAULT_DIV);
         pend_div <= '0;
         pend_idx <= '0;
         rr_ptr   <= '0;
      end else begin
         GNT  <= '0;
         TICK <= 1'b0;
         if (take) begin
            pend_idx <= arb_idx;
            pend_div <= sel_div;
         end
         if (apply) begin
            CUR_DIV <= pend_div;
            cnt     <= '0;
            CLK_OUT <= 1'b1;
            TICK    <= !CLK_OUT;
            GNT     <= {{(NREQ-1){1'b0}}, 1'b1} << pend_idx;
            rr_ptr  <= nxt_ptr;
         end else if (!hold) begin
            if (terminal) begin
               cnt     <= '0;
               CLK_OUT <= !CLK_OUT;
               TICK    <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: grant scoreboard plus CLK_OUT phase-length checks.
module tb_clk_div_ctrl;
   localparam int NREQ  = 2;
   localparam int CNT_W = 10;

   typedef struct {
      int idx;
      int div;
   } exp_t;

   logic                  CLK_IN = 1'b0;
   logic                  nRST;
   logic [NREQ-1:0]       REQ;
   logic [NREQ*CNT_W-1:0] DIV_REQ;
   logic [NREQ-1:0]       GNT;
   logic                  BUSY;
   logic [CNT_W-1:0]      CUR_DIV;
   logic                  CLK_OUT;
   logic                  TICK;
`ifdef CLK_DIV_CTRL_GATE_EN
   logic                  GATE;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   clk_div_ctrl #(.NREQ(NREQ), .CNT_W(CNT_W), .DEFAULT_DIV(1)) dut (
      .CLK_IN  (CLK_IN),
      .nRST    (nRST),
      .REQ     (REQ),
      .DIV_REQ (DIV_REQ),
`ifdef CLK_DIV_CTRL_GATE_EN
      .GATE    (GATE),
`endif
      .GNT     (GNT),
      .BUSY    (BUSY),
      .CUR_DIV (CUR_DIV),
      .CLK_OUT (CLK_OUT),
      .TICK    (TICK)
   );

   always #5 CLK_IN = ~CLK_IN;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int idx, input int div);
      exp_t e;
      e.idx = idx;
      e.div = div;
      sb.push_back(e);
   endtask

   // Waits (bounded) for a grant, starting with the current sample.
   task automatic wait_gnt(output int cycles);
      exp_t e;
      cycles = 0;
      while (GNT == '0 && cycles < 100) begin
         @(negedge CLK_IN);
         cycles++;
      end
      check("gnt_seen", 32'(GNT != '0), 1);
      check("sb_pending", 32'(sb.size() != 0), 1);
      if (GNT != '0 && sb.size() != 0) begin
         e = sb.pop_front();
         check("gnt_vec", 32'(GNT), 32'(1) << e.idx);
         check("gnt_cur_div", 32'(CUR_DIV), e.div);
         check("gnt_clk_high", 32'(CLK_OUT), 1);
         check("gnt_busy_low", 32'(BUSY), 0);
      end
   endtask

   // Called in a cycle where CLK_OUT has just risen; returns at the next rise.
   task automatic measure(input string tag, input int hi, input int lo);
      int nh, nl;
      nh = 1;
      nl = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge CLK_IN);
         if (CLK_OUT !== 1'b1) break;
         nh++;
      end
      for (int k = 0; k < 200; k++) begin
         if (CLK_OUT !== 1'b0) break;
         nl++;
         @(negedge CLK_IN);
      end
      check({tag, "_high"}, nh, hi);
      check({tag, "_low"}, nl, lo);
   endtask

   initial begin
      int cyc;
      nRST    = 1'b0;
      REQ     = '0;
      DIV_REQ = '0;
`ifdef CLK_DIV_CTRL_GATE_EN
      GATE    = 1'b0;
`endif
      repeat (5) @(negedge CLK_IN);
      check("rst_clk", 32'(CLK_OUT), 1);
      check("rst_div", 32'(CUR_DIV), 1);
      check("rst_gnt", 32'(GNT), 0);
      check("rst_busy", 32'(BUSY), 0);
      check("rst_tick", 32'(TICK), 0);
      nRST = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK_IN);
         check("div1_clk", 32'(CLK_OUT), (i % 2 == 0) ? 0 : 1);
         check("div1_tick", 32'(TICK), 1);
         check("div1_gnt", 32'(GNT), 0);
      end

      // Simultaneous requests with the pointer at 0.
      REQ = 2'b11;
      DIV_REQ[CNT_W-1:0]       = 10'd6;
      DIV_REQ[2*CNT_W-1:CNT_W] = 10'd8;
      push(0, 6);
      push(1, 8);
      @(negedge CLK_IN);
      check("sim_busy", 32'(BUSY), 1);
      wait_gnt(cyc);
      REQ = 2'b10;
      measure("sim_div6", 4, 4);
      wait_gnt(cyc);
      REQ = 2'b00;
      measure("sim_div8", 5, 5);

      // Single request, pointer back at 0.
      REQ = 2'b01;
      DIV_REQ[CNT_W-1:0] = 10'd4;
      push(0, 4);
      @(negedge CLK_IN);
      check("one_busy", 32'(BUSY), 1);
      check("one_gnt_early", 32'(GNT), 0);
      wait_gnt(cyc);
      REQ = 2'b00;
      measure("one_div4", 3, 3);

      // One-cycle request pulse is still latched and granted.
      REQ = 2'b10;
      DIV_REQ[2*CNT_W-1:CNT_W] = 10'd2;
      push(1, 2);
      @(negedge CLK_IN);
      REQ = 2'b00;
      check("wd_busy", 32'(BUSY), 1);
      wait_gnt(cyc);
      measure("wd_div2", 2, 2);

      // Reset while a request is pending: dropped with no grant.
      REQ = 2'b01;
      DIV_REQ[CNT_W-1:0] = 10'd10;
      @(negedge CLK_IN);
      REQ = 2'b00;
      check("rp_busy", 32'(BUSY), 1);
      nRST = 1'b0;
      @(negedge CLK_IN);
      check("rp_gnt", 32'(GNT), 0);
      check("rp_div", 32'(CUR_DIV), 1);
      check("rp_clk", 32'(CLK_OUT), 1);
      check("rp_busy_low", 32'(BUSY), 0);
      nRST = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK_IN);
         check("rp_no_gnt", 32'(GNT | {1'b0, BUSY}), 0);
      end

`ifdef CLK_DIV_CTRL_GATE_EN
      // Bring the divider to 4 from a rising cycle, then gate mid-high.
      while (CLK_OUT !== 1'b1) @(negedge CLK_IN);
      REQ = 2'b01;
      DIV_REQ[CNT_W-1:0] = 10'd4;
      push(0, 4);
      wait_gnt(cyc);
      REQ = 2'b00;
      @(negedge CLK_IN);
      GATE = 1'b1;
      for (int k = 0; k < 20 && CLK_OUT === 1'b1; k++) @(negedge CLK_IN);
      for (int k = 0; k < 20 && CLK_OUT === 1'b0; k++) @(negedge CLK_IN);
      check("gate_rise", 32'(CLK_OUT), 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK_IN);
         check("gate_frozen_clk", 32'(CLK_OUT), 1);
         check("gate_frozen_tick", 32'(TICK), 0);
      end
      REQ = 2'b10;
      DIV_REQ[2*CNT_W-1:CNT_W] = 10'd6;
      push(1, 6);
      @(negedge CLK_IN);
      wait_gnt(cyc);
      check("gate_gnt_latency", cyc + 1, 2);
      REQ  = 2'b00;
      GATE = 1'b0;
      measure("gate_resume", 4, 4);
`endif

      check("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
